// File: rtl/clk_wiz.sv
// ----------------------------------------------------------------------------
// clk_wiz
//
// Behavioural stand-in for the vendor clock wizard. It divides the board clock
// by an integer ratio, producing a registered output clock with nominal 50%
// duty, and raises a lock indicator once the output has run for a programmed
// number of complete periods.
//
// Parameters:
//   DIVIDE       output period in w_clk cycles (>= 2, even or odd)
//   LOCK_CYCLES  complete output periods before w_locked asserts (>= 1)
//
// Ports:
//   w_clk      in   board input clock (rising edge; falling edge for odd duty)
//   w_rst_n    in   asynchronous active-low reset
//   w_clk_out  out  divided clock, driven only from flops
//   w_locked   out  lock indicator, synchronous to w_clk, sticky until reset
//
// Optional build macro:
//   CLK_WIZ_GATE_UNTIL_LOCK_EN  hold w_clk_out low until w_locked is high
// ----------------------------------------------------------------------------
module clk_wiz #(
   parameter int DIVIDE      = 2,
   parameter int LOCK_CYCLES = 16
) (
   input  logic w_clk,
   input  logic w_rst_n,
   output logic w_clk_out,
   output logic w_locked
);

   localparam int CNT_W = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
   localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
   localparam bit ODD   = (DIVIDE % 2) == 1;

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DIVIDE - 1);
   // Rising-edge phase length: DIVIDE/2 for even, (DIVIDE-1)/2 for odd; the
   // odd case gains its extra half cycle from the falling-edge flop.
   localparam logic [CNT_W-1:0] POS_HIGH    = CNT_W'(DIVIDE / 2);
   localparam logic [LCK_W-1:0] LCK_TARGET  = LCK_W'(LOCK_CYCLES);

   if (DIVIDE < 2 || LOCK_CYCLES < 1) begin : g_param_check
      $error("clk_wiz: illegal parameters DIVIDE=%0d LOCK_CYCLES=%0d (need DIVIDE>=2, LOCK_CYCLES>=1)",
             DIVIDE, LOCK_CYCLES);
   end

   // -------------------------------------------------------------------------
   // Reset release synchronizer
   // -------------------------------------------------------------------------
   logic [1:0] sync_q;
   logic       run;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign run = sync_q[1];

   // -------------------------------------------------------------------------
   // Divide counter, lock tracking and rising-edge phase flop
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic             locked_q, locked_d;
   logic             pos_q, pos_d;
   logic             period_start;
   logic             phase_raw;

`ifdef CLK_WIZ_GATE_UNTIL_LOCK_EN
   logic             gate_q, gate_d;
   logic             gen_low;
`endif

   assign period_start = (div_cnt_q == '0);
   assign phase_raw    = (div_cnt_q < POS_HIGH);

   always_comb begin
      div_cnt_d  = div_cnt_q;
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      pos_d      = pos_q;
`ifdef CLK_WIZ_GATE_UNTIL_LOCK_EN
      gen_low    = ~w_clk_out;
      gate_d     = gate_q;
`endif

      if (run) begin
         div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + 1'b1;

         // Lock counter counts completed periods; on the start of the period
         // after LOCK_CYCLES completed ones, lock asserts.
         if (period_start && !locked_q) begin
            if (lock_cnt_q == LCK_TARGET) begin
               locked_d = 1'b1;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end

`ifdef CLK_WIZ_GATE_UNTIL_LOCK_EN
         // The gate only follows lock while the generated clock is low, and
         // uses the next-state lock so the first visible rise coincides with
         // the lock edge rather than one period later.
         if (gen_low) begin
            gate_d = locked_d;
         end
         pos_d = phase_raw & gate_d;
`else
         pos_d = phase_raw;
`endif
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         div_cnt_q  <= '0;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
         pos_q      <= 1'b0;
`ifdef CLK_WIZ_GATE_UNTIL_LOCK_EN
         gate_q     <= 1'b0;
`endif
      end else begin
         div_cnt_q  <= div_cnt_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
         pos_q      <= pos_d;
`ifdef CLK_WIZ_GATE_UNTIL_LOCK_EN
         gate_q     <= gate_d;
`endif
      end
   end

   assign w_locked = locked_q;

   // -------------------------------------------------------------------------
   // Output combine
   // -------------------------------------------------------------------------
   if (ODD) begin : g_odd
      // Falling-edge copy of the rising-edge phase stretches the high time by
      // half an input cycle. OR of two flops is glitch-free because the
      // negedge flop only changes while pos_q is stable and equal to it on
      // the rise, and only falls after pos_q has already fallen.
      logic neg_q;

      always_ff @(negedge w_clk or negedge w_rst_n) begin
         if (!w_rst_n) begin
            neg_q <= 1'b0;
         end else begin
            neg_q <= pos_q;
         end
      end

      assign w_clk_out = pos_q | neg_q;
   end else begin : g_even
      assign w_clk_out = pos_q;
   end

endmodule

// File: tb/tb_clk_wiz.sv
// ----------------------------------------------------------------------------
// tb_clk_wiz
//
// Directed bench for clk_wiz. Three instances run side by side on one board
// clock and one reset: (DIVIDE=2, LOCK=4), (DIVIDE=4, LOCK=1), (DIVIDE=3,
// LOCK=2). Edges E1, E2, ... are counted from reset release; outputs are
// sampled 1 time unit after each rising and falling board-clock edge.
// ----------------------------------------------------------------------------
module tb_clk_wiz;

   localparam int HALF = 5;
   localparam int PER  = 2 * HALF;

   logic       clk;
   logic       rst_n;
   logic [2:0] clk_o;
   logic [2:0] lck_o;
   bit         mon_en;

   int n_assert = 0;
   int n_fail   = 0;

   clk_wiz #(.DIVIDE(2), .LOCK_CYCLES(4)) u_a (
      .w_clk    (clk),
      .w_rst_n  (rst_n),
      .w_clk_out(clk_o[0]),
      .w_locked (lck_o[0])
   );

   clk_wiz #(.DIVIDE(4), .LOCK_CYCLES(1)) u_b (
      .w_clk    (clk),
      .w_rst_n  (rst_n),
      .w_clk_out(clk_o[1]),
      .w_locked (lck_o[1])
   );

   clk_wiz #(.DIVIDE(3), .LOCK_CYCLES(2)) u_c (
      .w_clk    (clk),
      .w_rst_n  (rst_n),
      .w_clk_out(clk_o[2]),
      .w_locked (lck_o[2])
   );

   initial clk = 1'b0;
   always #HALF clk = ~clk;

   function automatic int div_of(int i);
      case (i)
         0:       return 2;
         1:       return 4;
         default: return 3;
      endcase
   endfunction

   function automatic int lck_of(int i);
      case (i)
         0:       return 4;
         1:       return 1;
         default: return 2;
      endcase
   endfunction

   // Expected output after edge En (at_neg: after the falling edge that
   // follows En). Odd divides are high for (d+1)/2 rising-edge samples and
   // (d-1)/2 falling-edge samples of each period.
   function automatic logic exp_clk(int d, int l, int n, bit at_neg);
      int k;
      if (n < 3) return 1'b0;
`ifdef CLK_WIZ_GATE_UNTIL_LOCK_EN
      if (n < 3 + l * d) return 1'b0;
`endif
      k = (n - 3) % d;
      if (d % 2 == 0) return 1'(k < d / 2);
      if (at_neg)     return 1'(k < (d - 1) / 2);
      return 1'(k < (d + 1) / 2);
   endfunction

   function automatic logic exp_lock(int d, int l, int n);
      return 1'(n >= 3 + l * d);
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input longint obs, input longint lo,
                              input longint hi);
      n_assert++;
      assert ((obs >= lo && obs <= hi) === 1'b1)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
      end
   endtask

   task automatic check_step(input int n, input bit at_neg);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("clk_out[%0d] E%0d %s", i, n, at_neg ? "neg" : "pos"),
               clk_o[i], exp_clk(div_of(i), lck_of(i), n, at_neg));
         if (!at_neg)
            check($sformatf("locked[%0d] E%0d", i, n), lck_o[i],
                  exp_lock(div_of(i), lck_of(i), n));
      end
   endtask

   task automatic run_timeline(input int n_last);
      for (int n = 1; n <= n_last; n++) begin
         @(posedge clk); #1;
         check_step(n, 1'b0);
         @(negedge clk); #1;
         check_step(n, 1'b1);
      end
   endtask

   task automatic release_reset();
      @(negedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Edge counting and minimum pulse widths over the long window.
   for (genvar g = 0; g < 3; g++) begin : g_mon
      int  rises   = 0;
      bit  have_t  = 1'b0;
      time t_last  = 0;
      time min_hi  = 64'd1_000_000;
      time min_lo  = 64'd1_000_000;

      always @(clk_o[g]) begin
         if (mon_en) begin
            if (have_t) begin
               if (clk_o[g]) begin
                  if ($time - t_last < min_lo) min_lo = $time - t_last;
               end else begin
                  if ($time - t_last < min_hi) min_hi = $time - t_last;
               end
            end
            if (clk_o[g] === 1'b1) rises++;
            have_t = 1'b1;
            t_last = $time;
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      mon_en = 1'b0;

      // Reset held for 5 cycles: both outputs low throughout.
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            check($sformatf("rst clk_out[%0d] c%0d", i, c), clk_o[i], 1'b0);
            check($sformatf("rst locked[%0d] c%0d", i, c), lck_o[i], 1'b0);
         end
      end

      // First lock sequence from E1.
      release_reset();
      run_timeline(60);

      // E61: instance 0 is in its high phase. Assert reset between edges.
      @(posedge clk); #1;
      check("pre-reset clk_out[0] E61", clk_o[0], 1'b1);
      check("pre-reset locked[0] E61", lck_o[0], 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("async rst clk_out[%0d]", i), clk_o[i], 1'b0);
         check($sformatf("async rst locked[%0d]", i), lck_o[i], 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("held rst clk_out[%0d]", i), clk_o[i], 1'b0);
         check($sformatf("held rst locked[%0d]", i), lck_o[i], 1'b0);
      end

      // Full sequence restarts from E1.
      release_reset();
      run_timeline(60);

      // Long run after lock: edge count and no short pulses.
      mon_en = 1'b1;
      repeat (1000) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check_range("rises[0]", g_mon[0].rises, 1000 / 2 - 1, 1000 / 2 + 1);
      check_range("rises[1]", g_mon[1].rises, 1000 / 4 - 1, 1000 / 4 + 1);
      check_range("rises[2]", g_mon[2].rises, 1000 / 3 - 1, 1000 / 3 + 1);
      check_range("min_hi[0]", g_mon[0].min_hi, (2 / 2) * PER, 1000);
      check_range("min_lo[0]", g_mon[0].min_lo, (2 / 2) * PER, 1000);
      check_range("min_hi[1]", g_mon[1].min_hi, (4 / 2) * PER, 1000);
      check_range("min_lo[1]", g_mon[1].min_lo, (4 / 2) * PER, 1000);
      check_range("min_hi[2]", g_mon[2].min_hi, (3 / 2) * PER, 1000);
      check_range("min_lo[2]", g_mon[2].min_lo, (3 / 2) * PER, 1000);
      for (int i = 0; i < 3; i++)
         check($sformatf("locked[%0d] after long run", i), lck_o[i], 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
